// File: rtl/serial_frame_rx.sv
// SPI mode-0 slave that decodes 40-bit frames (8-bit address/flag byte and a 32-bit word)
// into register-file writes and reads. It counts frames that the host cuts short with cs_n.
module serial_frame_rx (
  input  logic        clock,
  input  logic        reset,
  input  logic        sclk,
  input  logic        cs_n,
  input  logic        mosi,
  output logic        miso,
  output logic [7:0]  adr_out,
  output logic [31:0] data_wr,
  input  logic [31:0] data_rd,
  output logic        frame_done,
  output logic [7:0]  abort_cnt
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  // Bit order in the synchronizer vectors: {mosi, cs_n, sclk}. Idle is cs_n high, sclk low.
  localparam logic [2:0] SYNC_IDLE = 3'b010;

  state_t      state_reg, state_next;
  logic [2:0]  sync1_reg, sync2_reg;
  logic        sclk_d_reg, cs_d_reg;
  logic [1:0]  warm_cnt_reg;
  logic        armed_reg;
  logic [4:0]  bit_cnt_reg;
  logic [31:0] shift_reg;
  logic [31:0] rd_sr_reg;
  logic        loaded_reg;
  logic        wr_flag_reg;
  logic [6:0]  adr_reg;
  logic        strobe_reg;
  logic [31:0] data_wr_reg;
  logic        frame_done_reg;
  logic [7:0]  abort_cnt_reg;

  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic in_frame, abort;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_reg  <= SYNC_IDLE;
      sync2_reg  <= SYNC_IDLE;
      sclk_d_reg <= 1'b0;
      cs_d_reg   <= 1'b1;
    end else begin
      sync1_reg  <= {mosi, cs_n, sclk};
      sync2_reg  <= sync1_reg;
      sclk_d_reg <= sync2_reg[0];
      cs_d_reg   <= sync2_reg[1];
    end
  end

  assign sclk_s = sync2_reg[0];
  assign cs_s   = sync2_reg[1];
  assign mosi_s = sync2_reg[2];

  // The reset value of the synchronizers is not a real sample. A frame may start only after
  // cs_n has been seen genuinely high, so a cs_n held low through reset cannot open a frame.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      warm_cnt_reg <= 2'd0;
      armed_reg    <= 1'b0;
    end else begin
      if (warm_cnt_reg != 2'd3)
        warm_cnt_reg <= warm_cnt_reg + 2'd1;
      armed_reg <= armed_reg | ((warm_cnt_reg == 2'd3) & cs_s);
    end
  end

  assign sclk_rise = sclk_s & ~sclk_d_reg;
  assign sclk_fall = ~sclk_s & sclk_d_reg;
  assign cs_rise   = cs_s & ~cs_d_reg;
  assign cs_fall   = ~cs_s & cs_d_reg & armed_reg;
  assign in_frame  = (state_reg == ADDR) || (state_reg == DATA);
  assign abort     = in_frame & cs_rise;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (cs_fall) state_next = ADDR;
      ADDR: begin
        if (cs_rise)                                 state_next = IDLE;
        else if (sclk_rise && bit_cnt_reg == 5'd7)   state_next = DATA;
      end
      DATA: begin
        if (cs_rise)                                 state_next = IDLE;
        else if (sclk_rise && bit_cnt_reg == 5'd31)  state_next = DONE;
      end
      DONE: if (cs_rise) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bit_cnt_reg    <= 5'd0;
      shift_reg      <= 32'h0;
      rd_sr_reg      <= 32'h0;
      loaded_reg     <= 1'b0;
      wr_flag_reg    <= 1'b0;
      adr_reg        <= 7'h0;
      strobe_reg     <= 1'b0;
      data_wr_reg    <= 32'h0;
      frame_done_reg <= 1'b0;
      abort_cnt_reg  <= 8'h0;
    end else begin
      strobe_reg     <= 1'b0;
      frame_done_reg <= 1'b0;
      if (state_reg == IDLE && cs_fall) begin
        bit_cnt_reg <= 5'd0;
        loaded_reg  <= 1'b0;
      end else if (abort) begin
        if (abort_cnt_reg != 8'hFF)
          abort_cnt_reg <= abort_cnt_reg + 8'd1;
      end else if (in_frame && sclk_rise) begin
        shift_reg   <= {shift_reg[30:0], mosi_s};
        bit_cnt_reg <= bit_cnt_reg + 5'd1;
        if (state_reg == ADDR && bit_cnt_reg == 5'd7) begin
          wr_flag_reg <= shift_reg[6];
          adr_reg     <= {shift_reg[5:0], mosi_s};
          bit_cnt_reg <= 5'd0;
        end
        if (state_reg == DATA && bit_cnt_reg == 5'd31) begin
          frame_done_reg <= 1'b1;
          if (wr_flag_reg) begin
            data_wr_reg <= {shift_reg[30:0], mosi_s};
            strobe_reg  <= 1'b1;
          end
        end
      end else if (state_reg == DATA && sclk_fall) begin
        // The first falling edge in DATA captures the word that the register file returns for the new address.
        if (!loaded_reg) begin
          rd_sr_reg  <= data_rd;
          loaded_reg <= 1'b1;
        end else begin
          rd_sr_reg  <= {rd_sr_reg[30:0], 1'b0};
        end
      end
    end
  end

  always_comb begin
    miso = 1'b0;
    if (state_reg == DATA && loaded_reg && !cs_s)
      miso = rd_sr_reg[31];
  end

  assign adr_out    = {strobe_reg, adr_reg};
  assign data_wr    = data_wr_reg;
  assign frame_done = frame_done_reg;
  assign abort_cnt  = abort_cnt_reg;

endmodule

// File: doc/serial_frame_rx.md
SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

Interface
REQ-001 SHALL have port: clock  input  1  system clock; all logic on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset; asserts immediately, releases synchronously to clock.
REQ-003 SHALL have port: sclk  input  1  serial clock from host, asynchronous to clock.
REQ-004 SHALL have port: cs_n  input  1  frame select, active-low, asynchronous.
REQ-005 SHALL have port: mosi  input  1  serial data in, MSB first.
REQ-006 SHALL have port: miso  output  1  serial read data out, MSB first.
REQ-007 SHALL have port: adr_out  output  8  register-file address; [6:0] address, [7] one-cycle write strobe.
REQ-008 SHALL have port: data_wr  output  32  write data to register file.
REQ-009 SHALL have port: data_rd  input  32  combinational read data from register file for adr_out[6:0].
REQ-010 SHALL have port: frame_done  output  1  one-cycle pulse per completed 40-bit frame.
REQ-011 SHALL have port: abort_cnt  output  8  count of frames cut short by cs_n.

Function
REQ-012 SHALL pass sclk, cs_n, mosi through two-flop synchronizers; all edge detection on synchronized values.
REQ-013 SHALL operate SPI mode 0: sample mosi on sclk rising edge, update miso on sclk falling edge; host guarantees sclk high and low phases of at least 4 clock periods each.
REQ-014 SHALL implement states IDLE, ADDR, DATA, DONE.
REQ-015 IDLE -> ADDR on synchronized cs_n falling edge; bit counter cleared to 0.
REQ-016 ADDR: shift 8 bits into address byte; bit 7 (first bit) is the write flag, bits 6:0 the address; after 8th rising edge -> DATA.
REQ-017 SHALL drive adr_out[6:0] with the new address the clock cycle after the 8th rising edge; adr_out[7] stays 0.
REQ-018 SHALL load a 32-bit read shift register from data_rd on the first synchronized sclk falling edge in DATA, presenting data_rd[31] on miso at that edge, then shift one bit per subsequent falling edge.
REQ-019 miso SHALL be 0 in IDLE, ADDR, DONE, and whenever synchronized cs_n is high.
REQ-020 DATA: shift 32 mosi bits; on 32nd rising edge (cycle N) -> DONE.
REQ-021 At cycle N+1: frame_done=1 for exactly one cycle; if write flag set, data_wr takes shifted word and adr_out[7]=1 for exactly that one cycle, simultaneously.
REQ-022 Read frames (write flag 0) SHALL NOT change data_wr and SHALL NOT assert adr_out[7].
REQ-023 DONE: ignore further sclk edges; return to IDLE on synchronized cs_n rising edge.
REQ-024 cs_n rising while in ADDR or DATA SHALL abort: -> IDLE, no strobe, no frame_done, data_wr unchanged, abort_cnt +1 saturating at 255.
REQ-025 cs_n falling coincident with a pending sclk edge: cs_n edge takes priority; that sclk edge is not counted.
REQ-026 adr_out[6:0] and data_wr SHALL hold their last values between frames.

Reset
REQ-027 On reset low: state IDLE, bit counter 0, adr_out=8'h00, data_wr=32'h0, miso=0, frame_done=0, abort_cnt=0, synchronizers cleared to idle (cs_n high, sclk low, mosi 0).
REQ-028 Reset asserted mid-frame SHALL discard the frame with no strobe; first frame after release begins only on a fresh cs_n falling edge.

Verification
REQ-029 Write frame addr byte 8'h87, data 32'hDEADBEEF -> one cycle with adr_out=8'h87, data_wr=32'hDEADBEEF, frame_done=1; then adr_out=8'h07.
REQ-030 Read frame addr byte 8'h04, data_rd model returns 32'hA5A5_0F0F for address 4 -> miso bits over 32 falling edges equal 32'hA5A50F0F; data_wr unchanged; adr_out[7] never 1.
REQ-031 Write frame to 8'h82 with cs_n raised after 20 data bits -> no strobe, no frame_done, abort_cnt 0->1.
REQ-032 300 aborted frames -> abort_cnt saturates at 8'hFF.
REQ-033 Write frame with 45 sclk cycles before cs_n rises -> exactly one strobe with the first 32 data bits; extra 5 bits ignored.
REQ-034 Assert reset during DATA of a write frame -> all outputs at reset values, no strobe; next full frame completes normally.
